// File: rtl/cpu_pkg.sv
// Shared definitions for the decode/execute slice of the CPU pipeline.
//   XZR       : index of the hard-wired zero register (reads as 0, never a
//               hazard source).
//   DW_DEF    : default datapath width.
//   AW_DEF    : default register index width.
//   fwd_sel_e : operand source chosen by the forwarding comparator.
package cpu_pkg;

  localparam int DW_DEF = 64;
  localparam int AW_DEF = 5;
  localparam logic [4:0] XZR = 5'd31;

  typedef enum logic [1:0] {
    FWD_NONE  = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/fwd_unit.sv
// Youngest-producer comparator for one source operand.
// Compares a source register index against two later pipeline producers and
// returns which one (if any) owns the newest value, plus the selected value.
// The "exmem" slot is the younger producer and wins over the "memwb" slot.
// The zero register never matches.
// Ports:
//   src_idx        in  source register index
//   reg_val        in  value to use when no producer matches
//   exmem_regwrite in  younger producer writes a register
//   exmem_rd       in  younger producer destination
//   exmem_result   in  younger producer value
//   memwb_regwrite in  older producer writes a register
//   memwb_rd       in  older producer destination
//   memwb_result   in  older producer value
//   fwd_sel        out which source was chosen
//   fwd_val        out chosen value
module fwd_unit
  import cpu_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int AW       = AW_DEF,
  parameter int ZERO_REG = 31
) (
  input  logic [AW-1:0] src_idx,
  input  logic [DW-1:0] reg_val,
  input  logic          exmem_regwrite,
  input  logic [AW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_regwrite,
  input  logic [AW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_result,
  output fwd_sel_e      fwd_sel,
  output logic [DW-1:0] fwd_val
);

  localparam logic [AW-1:0] ZR = AW'(ZERO_REG);

  always_comb begin
    fwd_sel = FWD_NONE;
    fwd_val = reg_val;
    if (src_idx != ZR) begin
      if (exmem_regwrite && (exmem_rd == src_idx)) begin
        fwd_sel = FWD_EXMEM;
        fwd_val = exmem_result;
      end else if (memwb_regwrite && (memwb_rd == src_idx)) begin
        fwd_sel = FWD_MEMWB;
        fwd_val = memwb_result;
      end
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with write-back bypass, hazard detection,
// EX-side operand forwarding and a saturating stall-cycle counter.
//
// Build option IDEX_FWD_EN:
//   defined   - EX/MEM and MEM/WB results are forwarded onto ex_a/ex_b;
//               only a load-use pair stalls (one cycle).
//   undefined - ex_a/ex_b are the registered operands; any in-flight
//               producer in EX or EX/MEM whose destination matches an ID
//               source stalls until the value reaches the write-back bypass
//               (at most two cycles).
//
// Handshake: stall is combinational and asks upstream to hold PC and IF/ID;
// while stall=1 a bubble (ex_valid=0) is written into ID/EX and the ID
// instruction must be presented again on the next cycle. flush kills the ID
// instruction and overrides stall. reset overrides both.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   id_*                            decoded instruction and regfile read data
//   flush                           taken branch, kill ID instruction
//   exmem_*, memwb_*                later-stage producers
//   stall                           hold PC and IF/ID
//   ex_valid, ex_a, ex_b            EX instruction valid and operands
//   ex_rn, ex_rm, ex_rd             registered register indices
//   ex_regwrite, ex_memread         registered controls (0 in a bubble)
//   stall_cnt                       saturating count of stall cycles
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int AW       = AW_DEF,
  parameter int ZERO_REG = 31
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rn,
  input  logic [AW-1:0] id_rm,
  input  logic [AW-1:0] id_rd,
  input  logic [DW-1:0] id_rd1,
  input  logic [DW-1:0] id_rd2,
  input  logic          id_regwrite,
  input  logic          id_memread,
  input  logic          flush,
  input  logic          exmem_regwrite,
  input  logic [AW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_regwrite,
  input  logic [AW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_result,
  output logic          stall,
  output logic          ex_valid,
  output logic [DW-1:0] ex_a,
  output logic [DW-1:0] ex_b,
  output logic [AW-1:0] ex_rn,
  output logic [AW-1:0] ex_rm,
  output logic [AW-1:0] ex_rd,
  output logic          ex_regwrite,
  output logic          ex_memread,
  output logic [31:0]   stall_cnt
);

  localparam logic [AW-1:0] ZR = AW'(ZERO_REG);

  logic          valid_q, valid_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [AW-1:0] rn_q, rn_d;
  logic [AW-1:0] rm_q, rm_d;
  logic [AW-1:0] rd_q, rd_d;
  logic          regwrite_q, regwrite_d;
  logic          memread_q, memread_d;
  logic [31:0]   stall_cnt_q, stall_cnt_d;

  logic          hazard;

`ifdef IDEX_FWD_EN
  fwd_sel_e fwd_sel_a, fwd_sel_b;
  logic     unused_fwd_sel;

  fwd_unit #(.DW(DW), .AW(AW), .ZERO_REG(ZERO_REG)) u_fwd_a (
    .src_idx        (rn_q),
    .reg_val        (a_q),
    .exmem_regwrite (exmem_regwrite),
    .exmem_rd       (exmem_rd),
    .exmem_result   (exmem_result),
    .memwb_regwrite (memwb_regwrite),
    .memwb_rd       (memwb_rd),
    .memwb_result   (memwb_result),
    .fwd_sel        (fwd_sel_a),
    .fwd_val        (ex_a)
  );

  fwd_unit #(.DW(DW), .AW(AW), .ZERO_REG(ZERO_REG)) u_fwd_b (
    .src_idx        (rm_q),
    .reg_val        (b_q),
    .exmem_regwrite (exmem_regwrite),
    .exmem_rd       (exmem_rd),
    .exmem_result   (exmem_result),
    .memwb_regwrite (memwb_regwrite),
    .memwb_rd       (memwb_rd),
    .memwb_result   (memwb_result),
    .fwd_sel        (fwd_sel_b),
    .fwd_val        (ex_b)
  );

  assign unused_fwd_sel = ^{fwd_sel_a, fwd_sel_b};

  // Only a load in EX cannot be forwarded in time.
  assign hazard = id_valid && valid_q && memread_q && (rd_q != ZR) &&
                  ((rd_q == id_rn) || (rd_q == id_rm));
`else
  // Without forwarding the comparator is pointed at the ID sources to find
  // any in-flight producer: EX is the younger slot, EX/MEM the older one.
  // regwrite_q is already zero for a bubble, so it carries ex_valid.
  fwd_sel_e      hz_sel_a, hz_sel_b;
  logic [DW-1:0] unused_hz_val_a, unused_hz_val_b;

  fwd_unit #(.DW(DW), .AW(AW), .ZERO_REG(ZERO_REG)) u_fwd_a (
    .src_idx        (id_rn),
    .reg_val        ('0),
    .exmem_regwrite (regwrite_q),
    .exmem_rd       (rd_q),
    .exmem_result   ('0),
    .memwb_regwrite (exmem_regwrite),
    .memwb_rd       (exmem_rd),
    .memwb_result   (exmem_result),
    .fwd_sel        (hz_sel_a),
    .fwd_val        (unused_hz_val_a)
  );

  fwd_unit #(.DW(DW), .AW(AW), .ZERO_REG(ZERO_REG)) u_fwd_b (
    .src_idx        (id_rm),
    .reg_val        ('0),
    .exmem_regwrite (regwrite_q),
    .exmem_rd       (rd_q),
    .exmem_result   ('0),
    .memwb_regwrite (exmem_regwrite),
    .memwb_rd       (exmem_rd),
    .memwb_result   (exmem_result),
    .fwd_sel        (hz_sel_b),
    .fwd_val        (unused_hz_val_b)
  );

  assign hazard = id_valid && ((hz_sel_a != FWD_NONE) || (hz_sel_b != FWD_NONE));
  assign ex_a   = a_q;
  assign ex_b   = b_q;
`endif

  // Reset releases the stall in the same cycle it is asserted.
  assign stall = hazard && !flush && !reset;

  always_comb begin
    rn_d = id_rn;
    rm_d = id_rm;
    rd_d = id_rd;

    // Operand capture: zero register, then same-cycle regfile write bypass.
    if (id_rn == ZR)                                  a_d = '0;
    else if (memwb_regwrite && (memwb_rd == id_rn))   a_d = memwb_result;
    else                                              a_d = id_rd1;

    if (id_rm == ZR)                                  b_d = '0;
    else if (memwb_regwrite && (memwb_rd == id_rm))   b_d = memwb_result;
    else                                              b_d = id_rd2;

    if (flush || stall || !id_valid) begin
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
      memread_d  = 1'b0;
    end else begin
      valid_d    = 1'b1;
      regwrite_d = id_regwrite;
      memread_d  = id_memread;
    end

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      rn_q        <= '0;
      rm_q        <= '0;
      rd_q        <= '0;
      regwrite_q  <= 1'b0;
      memread_q   <= 1'b0;
      stall_cnt_q <= 32'd0;
    end else begin
      valid_q     <= valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rn_q        <= rn_d;
      rm_q        <= rm_d;
      rd_q        <= rd_d;
      regwrite_q  <= regwrite_d;
      memread_q   <= memread_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_valid    = valid_q;
  assign ex_rn       = rn_q;
  assign ex_rm       = rm_q;
  assign ex_rd       = rd_q;
  assign ex_regwrite = regwrite_q;
  assign ex_memread  = memread_q;
  assign stall_cnt   = stall_cnt_q;

endmodule
